sub_bytes_engine: RTL
=====================

# sub_bytes_engine

Parametrised, multi-cycle AES SubBytes engine. It accepts a state of BYTES bytes and substitutes LANES bytes per clock through LANES shared S-box instances. It supports both the forward S-box (encryption) and the inverse S-box (decryption), selected per transaction. Valid/ready handshakes on input and output let it sit between the round-key adder and the ShiftRows stage of the iterative AES datapath.

## Interface
- BYTES, 16, number of bytes in the state; byte k occupies bits [8k+7:8k].
- LANES, 4, S-box instances (bytes substituted per cycle); legal values are 1, 2, 4, 8, 16. BYTES % LANES must be 0; any other value is an elaboration error.
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data and in_inv are valid.
- in_ready  output  1  engine can accept a state this cycle.
- in_data  input  8*BYTES  state to substitute.
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; latched at accept.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8*BYTES  substituted state.
- busy  output  1  high in RUN.

## Operation
- Registers:
  - work register W, 8*BYTES bits.
  - mode bit M.
  - lane counter C, width clog2(BYTES/LANES), minimum 1.
  - state machine with states IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- out_valid = (state==DONE).
- busy = (state==RUN).
- out_data = W at all times; it is only meaningful while out_valid is high.
- Accept occurs when in_valid & in_ready:
  - W <= in_data, M <= in_inv, C <= 0, state <= RUN.
- In RUN, each cycle:
  - bytes C*LANES .. C*LANES+LANES-1 of W are replaced by S(byte) if M=0, or by S⁻¹(byte) if M=1.
  - If C == BYTES/LANES-1, then state <= DONE. Otherwise C <= C+1.
- DONE with out_ready=1:
  - If an accept occurs in the same cycle, go to RUN with the new data (back-to-back).
  - Otherwise go to IDLE.
- DONE with out_ready=0: hold. W, M and out_valid remain stable.
- Inputs are ignored while in_ready=0, including in_inv changes during RUN.
- S-box and inverse S-box are the FIPS-197 tables, purely combinational per lane. Each lane is muxed by M; no register sits inside the lane.
- Reset, whether asserted at any time or mid-RUN: state=IDLE, W=0, M=0, C=0. An in-flight transaction is discarded with no output.

## Timing
- Reset values:
  - in_ready=1 once rst_n is high; it is combinational from state and is 1 in IDLE.
  - out_valid=0, busy=0, out_data=0.
- Latency, with N = BYTES/LANES:
  - The accept edge is E0.
  - Substitution occurs on edges E1..EN.
  - out_valid is high after EN.
  - With defaults, N=4.
  - LANES=BYTES gives N=1, so out_valid is high the cycle after accept.
- Throughput: with out_ready held high and in_valid held high, one state every N+1 cycles. The DONE cycle overlaps the next accept.
- The out_valid/out_data pair must not change while out_valid=1 and out_ready=0.
- in_ready is combinational on out_ready in DONE. There is no combinational path from in_valid to any output.

## Test plan
- Reset and basic forward substitution, defaults (BYTES=16, LANES=4):
  - Stimulus: reset, then send in_data with every byte 0xC2, in_inv=0.
  - Response: out_valid rises 4 edges after accept, and every out_data byte is 0x25.
- Mixed bytes, forward then inverse:
  - Stimulus: bytes 0x00, 0x01, 0x53, 0xFF (repeated), in_inv=0.
  - Response: out_data bytes 0x63, 0x7C, 0xED, 0x16.
  - Stimulus: feed that result back with in_inv=1.
  - Response: original bytes returned.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises, and toggle in_valid/in_data/in_inv meanwhile.
  - Response: out_data stable, in_ready=0, and exactly one result is delivered when out_ready goes to 1.
- Back-to-back:
  - Stimulus: in_valid and out_ready held at 1 with three different states.
  - Response: results appear at 5-cycle spacing, in order, with correct substitution.
  - Stimulus: mode changes between transactions.
  - Response: the mode is honoured per transaction.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 on the 2nd RUN cycle.
  - Response: out_valid=0, out_data=0 immediately (asynchronously), busy=0, and no result is emitted. A subsequent transaction completes correctly.
- Parameter sweep:
  - Stimulus: LANES=1, 2, 8, 16 with random states in both modes.
  - Response: latency is 16, 8, 2, 1 edges respectively, and results match the reference model table lookup.

Source files
------------

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: multi-cycle AES SubBytes (forward/inverse) over LANES shared S-boxes
module sub_bytes_engine #(
  parameter int BYTES = 16,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*BYTES-1:0] out_data,
  output logic               busy
);
  localparam int N  = BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(8 * BYTES);

  if ((LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) ||
      (BYTES % LANES != 0)) begin : g_bad_params
    $error("sub_bytes_engine: illegal LANES/BYTES combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [8*BYTES-1:0] w;
  logic               m;
  logic [CW-1:0]      c;
  logic               accept, last;
  logic [7:0]         lane_in  [LANES];
  logic [7:0]         lane_out [LANES];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      r = r ^ (b[i] ? p : 8'h00);
      p = xtime(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign out_data  = w;
  assign accept    = in_valid & in_ready;
  assign last      = (c == CW'(N - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l]  = w[IW'(8 * (int'(c) * LANES + l)) +: 8];
    assign lane_out[l] = m ? inv_sbox(lane_in[l]) : fwd_sbox(lane_in[l]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  // Next state: accept wins (IDLE or DONE), RUN ends on the last lane group, DONE drains on out_ready.
  always_comb begin
    state_n = state;
    state_n = accept ? RUN :
              (state == RUN && last) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end

  // Work register, mode and lane counter: load on accept, substitute one lane group per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w <= '0;
      m <= 1'b0;
      c <= '0;
    end else if (accept) begin
      w <= in_data;
      m <= in_inv;
      c <= '0;
    end else if (state == RUN) begin
      for (int j = 0; j < LANES; j++) w[IW'(8 * (int'(c) * LANES + j)) +: 8] <= lane_out[j];
      if (!last) c <= c + 1'b1;
    end
  end
endmodule
